// File: rtl/led_matrix_pkg.sv
// -----------------------------------------------------------------------------
// led_matrix_pkg
// Shared definitions for the LED matrix scan decoder and the matrix driver:
// matrix geometry, the scan decoder FSM state type, the frame type and a small
// helper that counts how many row selects are active (low).
// -----------------------------------------------------------------------------
package led_matrix_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,  // no row selected
    SETTLE = 2'd1,  // a row is selected, waiting for the inputs to stabilise
    HELD   = 2'd2   // this dwell has already been captured (or rejected)
  } scan_state_e;

  // frame[i][j] is row i, column j.
  typedef logic [ROWS-1:0][COLS-1:0] frame_t;

  // Number of active-low row selects that are asserted.
  function automatic logic [3:0] count_low(input logic [ROWS-1:0] rows);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < ROWS; i++) begin
      n = n + {3'b000, ~rows[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/led_matrix_scan_decoder_if.sv
// -----------------------------------------------------------------------------
// led_matrix_scan_decoder_if
// Bundles the scanned matrix pins and the decoded frame outputs.
//   row_sink     : active-low row select (bit i low selects row i)
//   red_driver   : active-high red column data for the selected row
//   green_driver : active-high green column data for the selected row
//   red_array    : last complete red frame, [row][column]
//   green_array  : last complete green frame, [row][column]
//   frame_done   : one-cycle pulse when both arrays update
//   row_err      : one-cycle pulse when a stable sample selects several rows
// Modports: master = the side driving the matrix pins, slave = the decoder.
// -----------------------------------------------------------------------------
interface led_matrix_scan_decoder_if;
  import led_matrix_pkg::*;

  logic [ROWS-1:0] row_sink;
  logic [COLS-1:0] red_driver;
  logic [COLS-1:0] green_driver;
  frame_t          red_array;
  frame_t          green_array;
  logic            frame_done;
  logic            row_err;

  modport master (
    output row_sink, red_driver, green_driver,
    input  red_array, green_array, frame_done, row_err
  );

  modport slave (
    input  row_sink, red_driver, green_driver,
    output red_array, green_array, frame_done, row_err
  );

endinterface

// File: rtl/led_scan_sync.sv
// -----------------------------------------------------------------------------
// led_scan_sync
// Two-flop synchronizer for a bus of asynchronous matrix pins.
//   clk   : destination clock
//   reset : asynchronous active-high reset, clears both flop stages
//   d_i   : asynchronous input bus
//   q_o   : synchronized output bus (two clock edges of latency)
// -----------------------------------------------------------------------------
module led_scan_sync #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // NOTE: non-blocking assignments make both stages sample their pre-edge
  // values, so the data really passes through two flops rather than one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/led_matrix_scan_decoder.sv
// -----------------------------------------------------------------------------
// led_matrix_scan_decoder
// Reconstructs red/green frames from a row-scanned LED matrix. Pins are
// synchronized, a row is captured into a shadow frame once its pins have been
// stable long enough, and the shadow is published when all rows have been seen.
//   clk   : sole clock, rising edge
//   reset : asynchronous active-high reset
//   bus   : slave side of led_matrix_scan_decoder_if (pins in, frames out)
// Parameter STABLE_CYCLES (2..255): identical consecutive samples needed
// before a row is captured.
// -----------------------------------------------------------------------------
module led_matrix_scan_decoder
  import led_matrix_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input logic                      clk,
  input logic                      reset,
  led_matrix_scan_decoder_if.slave bus
);

  localparam int         SW      = ROWS + 2 * COLS;
  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);
  // Counter value from which the next stable edge reaches CNT_MAX.
  localparam logic [7:0] CNT_ARM = 8'(STABLE_CYCLES - 2);

  logic [SW-1:0]   pins;
  logic [SW-1:0]   sample;
  logic [SW-1:0]   prev_q;
  logic [ROWS-1:0] row_s;
  logic [COLS-1:0] red_s;
  logic [COLS-1:0] green_s;

  scan_state_e     state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [ROWS-1:0] mask_q, mask_d;
  frame_t          shadow_red_q, shadow_red_d;
  frame_t          shadow_green_q, shadow_green_d;
  frame_t          red_arr_q, red_arr_d;
  frame_t          green_arr_q, green_arr_d;
  logic            frame_done_q, frame_done_d;
  logic            row_err_q, row_err_d;

  logic            changed;
  logic            row_idle;
  logic            capture;

  assign pins = {bus.row_sink, bus.red_driver, bus.green_driver};

  led_scan_sync #(.WIDTH(SW)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (pins),
    .q_o  (sample)
  );

  assign row_s   = sample[SW-1 -: ROWS];
  assign red_s   = sample[2*COLS-1 -: COLS];
  assign green_s = sample[COLS-1:0];

  assign changed  = (sample != prev_q);
  assign row_idle = &row_s;
  // Capture on the edge where the stability counter reaches CNT_MAX; once
  // saturated it stays there, so a long dwell never re-arms the capture.
  assign capture  = (state_q == SETTLE) && !changed && !row_idle && (cnt_q == CNT_ARM);

  // NOTE: every variable gets its default first so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mask_d         = mask_q;
    shadow_red_d   = shadow_red_q;
    shadow_green_d = shadow_green_q;
    red_arr_d      = red_arr_q;
    green_arr_d    = green_arr_q;
    frame_done_d   = 1'b0;
    row_err_d      = 1'b0;

    if (changed) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 8'd1;
    end

    unique case (state_q)
      IDLE:    if (!row_idle) state_d = SETTLE;
      SETTLE:  if (row_idle) state_d = IDLE;
               else if (capture) state_d = HELD;
      HELD:    if (changed) state_d = row_idle ? IDLE : SETTLE;
      default: state_d = IDLE;
    endcase

    if (capture) begin
      if (count_low(row_s) == 4'd1) begin
        for (int r = 0; r < ROWS; r++) begin
          if (!row_s[r]) begin
            shadow_red_d[r]   = red_s;
            shadow_green_d[r] = green_s;
          end
        end
        mask_d = mask_q | ~row_s;
        // Publish on the same edge, including the row just written.
        if (&mask_d) begin
          red_arr_d    = shadow_red_d;
          green_arr_d  = shadow_green_d;
          mask_d       = '0;
          frame_done_d = 1'b1;
        end
      end else begin
        row_err_d = 1'b1;
      end
    end
  end

  // NOTE: the shadow rows are reset along with everything else so a reset
  // can never leave stale rows that leak into the next published frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_q         <= '0;
      state_q        <= IDLE;
      cnt_q          <= '0;
      mask_q         <= '0;
      shadow_red_q   <= '0;
      shadow_green_q <= '0;
      red_arr_q      <= '0;
      green_arr_q    <= '0;
      frame_done_q   <= 1'b0;
      row_err_q      <= 1'b0;
    end else begin
      prev_q         <= sample;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mask_q         <= mask_d;
      shadow_red_q   <= shadow_red_d;
      shadow_green_q <= shadow_green_d;
      red_arr_q      <= red_arr_d;
      green_arr_q    <= green_arr_d;
      frame_done_q   <= frame_done_d;
      row_err_q      <= row_err_d;
    end
  end

  assign bus.red_array   = red_arr_q;
  assign bus.green_array = green_arr_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.row_err     = row_err_q;

endmodule

// File: tb/tb_led_matrix_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_led_matrix_scan_decoder
// Drives scanned rows into the decoder and compares every cycle against a
// run-length reference: a pin pattern held for S consecutive edges is
// captured two edges after the S-th edge, once per run.
// -----------------------------------------------------------------------------
module tb_led_matrix_scan_decoder;
  import led_matrix_pkg::*;

  localparam int S = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  led_matrix_scan_decoder_if bus();

  led_matrix_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int fd_seen  = 0;
  int err_seen = 0;

  // ---------------- reference model ----------------
  logic [7:0]  sh_red [8];
  logic [7:0]  sh_green [8];
  logic [7:0]  exp_red [8];
  logic [7:0]  exp_green [8];
  logic [7:0]  m_mask;
  logic        exp_fd;
  logic        exp_err;
  logic [23:0] run_val;
  int          run_len;
  logic        pend_v [2];
  logic [23:0] pend_p [2];

  function automatic logic [63:0] pack(input logic [7:0] a [8]);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = a[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      sh_red[i] = 8'h00; sh_green[i] = 8'h00;
      exp_red[i] = 8'h00; exp_green[i] = 8'h00;
    end
    m_mask  = 8'h00;
    exp_fd  = 1'b0;
    exp_err = 1'b0;
    run_val = 24'h0;
    run_len = 0;
    for (int i = 0; i < 2; i++) begin
      pend_v[i] = 1'b0; pend_p[i] = 24'h0;
    end
  endtask

  task automatic model_apply(input logic [23:0] p);
    logic [7:0] rows;
    int nlow;
    int r;
    rows = p[23:16];
    nlow = $countones(~rows);
    if (nlow == 1) begin
      r = 0;
      for (int i = 0; i < 8; i++) if (!rows[i]) r = i;
      sh_red[r]   = p[15:8];
      sh_green[r] = p[7:0];
      m_mask[r]   = 1'b1;
      if (m_mask == 8'hFF) begin
        for (int i = 0; i < 8; i++) begin
          exp_red[i] = sh_red[i]; exp_green[i] = sh_green[i];
        end
        m_mask = 8'h00;
        exp_fd = 1'b1;
      end
    end else begin
      exp_err = 1'b1;
    end
  endtask

  // Called right after each rising edge with the pins that edge sampled.
  task automatic model_edge(input logic [23:0] p);
    exp_fd  = 1'b0;
    exp_err = 1'b0;
    if (pend_v[1]) model_apply(pend_p[1]);
    pend_v[1] = pend_v[0];
    pend_p[1] = pend_p[0];
    if (run_len > 0 && p == run_val) run_len++;
    else begin
      run_val = p;
      run_len = 1;
    end
    pend_v[0] = (run_len == S) && (p[23:16] != 8'hFF);
    pend_p[0] = p;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      check("red_array",   64'(bus.red_array),   pack(exp_red));
      check("green_array", 64'(bus.green_array), pack(exp_green));
      check("frame_done",  64'(bus.frame_done),  64'(exp_fd));
      check("row_err",     64'(bus.row_err),     64'(exp_err));
      if (bus.frame_done === 1'b1) fd_seen++;
      if (bus.row_err === 1'b1) err_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle(input logic [7:0] row, input logic [7:0] red, input logic [7:0] green);
    @(negedge clk);
    bus.row_sink     = row;
    bus.red_driver   = red;
    bus.green_driver = green;
    @(posedge clk);
    model_edge({row, red, green});
  endtask

  task automatic hold(input logic [7:0] row, input logic [7:0] red, input logic [7:0] green, input int n);
    repeat (n) cycle(row, red, green);
  endtask

  task automatic blank(input int n);
    hold(8'hFF, 8'h00, 8'h00, n);
  endtask

  function automatic logic [7:0] sel(input int r);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << r);
  endfunction

  task automatic do_reset(input int n);
    @(posedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    repeat (n) @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic random_frames(input int nframes);
    int order [8];
    int j, t, a, b, dwell;
    logic [7:0] row;
    for (int f = 0; f < nframes; f++) begin
      for (int i = 0; i < 8; i++) order[i] = i;
      for (int i = 7; i > 0; i--) begin
        j = $urandom_range(i, 0);
        t = order[i]; order[i] = order[j]; order[j] = t;
      end
      for (int i = 0; i < 8; i++) begin
        row = sel(order[i]);
        if ($urandom_range(5, 0) == 0) begin
          a = $urandom_range(7, 0);
          b = (a + $urandom_range(7, 1)) % 8;
          row = sel(a) & sel(b);
        end
        dwell = $urandom_range(7, 2);
        hold(row, 8'($urandom), 8'($urandom), dwell);
        blank($urandom_range(2, 0));
      end
    end
  endtask

  initial begin : main
    int fd0, er0;
    logic [63:0] snap;
    bus.row_sink = 8'hFF; bus.red_driver = 8'h00; bus.green_driver = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("reset_red", 64'(bus.red_array), 64'h0);
    check("reset_pulses", {62'h0, bus.frame_done, bus.row_err}, 64'h0);

    // Diagonal frame, rows 0..7 in order.
    fd0 = fd_seen; er0 = err_seen;
    for (int i = 0; i < 8; i++) hold(sel(i), 8'h01 << i, 8'h00, 6);
    blank(3);
    #1;
    check("diag_fd_count", 64'(fd_seen - fd0), 64'd1);
    check("diag_red", 64'(bus.red_array), 64'h8040_2010_0804_0201);
    check("diag_green", 64'(bus.green_array), 64'h0);
    check("diag_err_count", 64'(err_seen - er0), 64'd0);

    // Too short a dwell: nothing captured.
    fd0 = fd_seen; er0 = err_seen;
    hold(sel(3), 8'hFF, 8'hFF, 3);
    blank(4);
    #1;
    check("short_pulses", 64'((fd_seen - fd0) + (err_seen - er0)), 64'd0);

    // Two rows selected at once.
    hold(8'b1111_0011, 8'hFF, 8'hFF, 6);
    blank(3);
    #1;
    check("multi_err_count", 64'(err_seen - er0), 64'd1);
    check("multi_fd_count", 64'(fd_seen - fd0), 64'd0);
    check("multi_red_kept", 64'(bus.red_array), 64'h8040_2010_0804_0201);

    // Seven rows without row 3: no frame, so row 3 was never captured above.
    for (int i = 0; i < 8; i++) if (i != 3) hold(sel(i), 8'h11, 8'h22, 6);
    blank(3);
    #1;
    check("no_row3_fd_count", 64'(fd_seen - fd0), 64'd0);

    // Partial scan, reset, then a fresh full scan.
    do_reset(2);
    fd0 = fd_seen;
    for (int i = 0; i < 7; i++) hold(sel(i), 8'h5A, 8'hA5, 6);
    do_reset(2);
    #1;
    check("midreset_red", 64'(bus.red_array), 64'h0);
    for (int i = 0; i < 8; i++) hold(sel(i), 8'hFF, 8'hFF, 6);
    blank(3);
    #1;
    check("rescan_fd_count", 64'(fd_seen - fd0), 64'd1);
    check("rescan_red", 64'(bus.red_array), 64'hFFFF_FFFF_FFFF_FFFF);
    check("rescan_green", 64'(bus.green_array), 64'hFFFF_FFFF_FFFF_FFFF);

    // Out-of-order scan with row 5 rewritten.
    fd0 = fd_seen;
    hold(sel(7), 8'h17, 8'hC7, 6);
    hold(sel(5), 8'hAA, 8'hC5, 6);
    hold(sel(3), 8'h13, 8'hC3, 6);
    hold(sel(1), 8'h11, 8'hC1, 6);
    hold(sel(0), 8'h10, 8'hC0, 6);
    hold(sel(5), 8'h55, 8'hC5, 6);
    hold(sel(2), 8'h12, 8'hC2, 6);
    hold(sel(4), 8'h14, 8'hC4, 6);
    blank(3);
    #1;
    check("order_early_fd", 64'(fd_seen - fd0), 64'd0);
    hold(sel(6), 8'h16, 8'hC6, 6);
    blank(3);
    #1;
    snap = bus.red_array;
    check("order_fd_count", 64'(fd_seen - fd0), 64'd1);
    check("order_red_row5", 64'(snap[47:40]), 64'h55);

    // Diagonal again with blanking between rows.
    fd0 = fd_seen; er0 = err_seen;
    for (int i = 0; i < 8; i++) begin
      hold(sel(i), 8'h01 << i, 8'h00, 6);
      blank(4);
    end
    #1;
    check("blank_fd_count", 64'(fd_seen - fd0), 64'd1);
    check("blank_red", 64'(bus.red_array), 64'h8040_2010_0804_0201);
    check("blank_err_count", 64'(err_seen - er0), 64'd0);

    // Randomized scans against the reference.
    random_frames(12);
    blank(4);
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/led_matrix_scan_decoder.md
LED_MATRIX_SCAN_DECODER -- requirements
Module: led_matrix_scan_decoder

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter STABLE_CYCLES, default 4, consecutive identical synchronized samples required before a row is captured (legal 2..255).
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous active-high reset.
REQ-005 Port row_sink  input  8  scanned row select, active-low; bit i low selects row i.
REQ-006 Port red_driver  input  8  active-high red column data for the selected row; bit j is column j.
REQ-007 Port green_driver  input  8  active-high green column data; bit j is column j.
REQ-008 Port red_array  output  8x8  last complete red frame; red_array[i][j] is row i, column j.
REQ-009 Port green_array  output  8x8  last complete green frame, same indexing.
REQ-010 Port frame_done  output  1  one-cycle pulse when red_array and green_array update.
REQ-011 Port row_err  output  1  one-cycle pulse when a stable sample has more than one row_sink bit low.

Function
REQ-012 SHALL pass all 24 input bits through a 2-flop synchronizer; "sample" below means the synchronizer output.
REQ-013 SHALL keep a saturating stability counter:
- cleared to 0 when sample differs from the previous cycle's sample;
- otherwise incremented, saturating at STABLE_CYCLES-1.
REQ-014 SHALL implement FSM states IDLE, SETTLE, HELD.
REQ-015 IDLE -> SETTLE when sample row_sink is not all-ones.
REQ-016 SETTLE -> HELD on the edge where the counter reaches STABLE_CYCLES-1.
REQ-017 SETTLE -> IDLE when row_sink returns to all-ones.
REQ-018 HELD -> SETTLE when the sample changes and the new row_sink is not all-ones.
REQ-019 HELD -> IDLE when the sample changes and the new row_sink is all-ones.
REQ-020 On the SETTLE->HELD edge with exactly one row_sink bit low (row r), SHALL:
- write the red and green sample bits into shadow row r;
- set row-mask bit r.
REQ-021 On the SETTLE->HELD edge with two or more row_sink bits low, SHALL write nothing, leave the mask unchanged, and assert row_err for the next cycle only.
REQ-022 While in HELD, SHALL perform at most one capture per dwell regardless of dwell length.
REQ-023 Recapturing a row whose mask bit is already set SHALL overwrite that shadow row with no error.
REQ-024 When a capture makes the row-mask all-ones, on the same edge SHALL:
- copy the shadow, including the row just written, to red_array/green_array;
- clear the mask;
- assert frame_done for the following cycle only.
REQ-025 Outputs SHALL hold their values between frame_done pulses; partial frames are never visible.
REQ-026 Latency: a row held constant at the pins reaches the shadow 2 + STABLE_CYCLES clock edges after it first appears.
REQ-027 Scan order is irrelevant; any order covering all 8 rows completes a frame.
REQ-028 frame_done and row_err SHALL never both be asserted in the same cycle.

Reset
REQ-029 Asserting reset SHALL immediately force:
- FSM to IDLE;
- synchronizer flops, shadow and mask to 0;
- stability counter to 0;
- red_array, green_array, frame_done and row_err to 0.
REQ-030 Reset mid-frame SHALL discard all partially captured rows; the first frame_done after reset requires all 8 rows to be captured afresh.

Structure
REQ-031 Package led_matrix_pkg SHALL hold ROWS=8, COLS=8 and the FSM state enum; the package is shared with the matrix driver.
REQ-032 The synchronizer SHALL be sub-module led_scan_sync, parameterized by width and instantiated with width 24.

Verification
REQ-033 Scan rows 0..7 in order, 6 cycles each, red row i = 8'h01<<i, green = 8'h00 -> after row 7 capture, frame_done pulses once, red_array is a diagonal, green_array is all 0.
REQ-034 Hold row 3 for only 3 cycles with STABLE_CYCLES=4 -> no capture, mask unchanged, no pulses.
REQ-035 Hold row_sink=8'b1111_0011 stable for 6 cycles -> row_err pulses exactly once, no frame_done, arrays unchanged.
REQ-036 Scan rows 0..6, assert reset, then scan rows 0..7 with all-ones data -> exactly one frame_done (after the second scan), both arrays all-ones.
REQ-037 Scan order 7,5,3,1,0,2,4,6 with row 5 repeated (first 8'hAA, then 8'h55) -> frame_done after row 6, red_array[5]=8'h55.
REQ-038 Insert 4 all-ones blanking cycles between rows -> same arrays as without blanking, no row_err.
